param_bus_datapath: RTL and testbench
=====================================

Name: param_bus_datapath

Overview:
Parametrised successor to the single-bus CPU datapath. It provides:
- a configurable-width, configurable-depth register file;
- the special registers PC, IR, MAR, MDR, Y, Z, HI and LO, with encoded bus-source selection;
- an ALU with single-cycle operations and new multi-cycle signed MUL/DIV under a busy/done handshake.

The control unit drives it. The memory model attaches through the MAR/MDR ports.

Parameters:
WIDTH, 32, datapath width in bits (>=8)
NREGS, 16, general registers (power of 2, >=2)
SELW, $clog2(NREGS+8), bus-source select width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
src_en  in  1  bus driven when 1, else bus=0
src_sel  in  SELW  0..NREGS-1=Rn; NREGS+0 HI, +1 LO, +2 ZHI, +3 ZLO, +4 PC, +5 MDR, +6 IMM; other codes give bus=0
ba_mode  in  1  R0 reads as 0 on the bus
reg_we  in  1  write bus into register reg_widx
reg_widx  in  $clog2(NREGS)  destination register
pcin, irin, marin, yin, hiin, loin, mdrin  in  1 each  load from bus (MDR via mdr_sel)
mdr_sel  in  2  0=bus, 1=mem_rdata, 2=imm, 3=zero
imm  in  WIDTH  immediate / sign-extended C
mem_rdata  in  WIDTH  memory read data
alu_op  in  4  operation code
zin  in  1  capture ALU result / start MUL/DIV
bus  out  WIDTH  bus value
pc, ir, mar, mdr, y, hi, lo  out  WIDTH each  register values
z  out  2*WIDTH  Z register
busy  out  1  MUL/DIV in progress
done  out  1  one-cycle completion pulse
dbz  out  1  sticky divide-by-zero flag

Behaviour:
- Reset: all registers, z, busy, done and dbz go to 0. Reset mid-MUL/DIV aborts the operation; no done pulse follows.
- Bus is combinational from the current register values. A write to the selected source lands at the edge; the bus shows the old value in that cycle.
- src_sel=0 with ba_mode=1 gives bus=0; R0 itself is unchanged.
- Simultaneous loads of several destinations from the bus are legal.
- Operand A is y; operand B is bus.
- Single-cycle ops:
  - ADD 0, SUB 1, AND 2, OR 3
  - SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8 (shift amount = B[$clog2(WIDTH)-1:0])
  - NEG 9 (-B), NOT 10 (~B), PASS 11 (B), INCPC 12 (B+1)
  - With zin=1, on the edge: z <= {WIDTH'b0, result}. Carries and overflow are discarded.
- Multi-cycle ops: MUL 13 (signed A*B), DIV 14 (signed A/B, truncating).
  - Start: zin=1 while idle. A and B are captured at that edge.
  - busy=1 for exactly WIDTH cycles after the start edge.
  - z is written at the edge ending the last busy cycle. done=1 for the following cycle, and z is valid in that cycle.
  - MUL result: z=full 2*WIDTH-bit product.
  - DIV result: z[2W-1:W]=remainder (sign of A), z[W-1:0]=quotient.
- Divide by zero still takes WIDTH cycles, then gives z={A, all-ones} and dbz=1. dbz clears on the next MUL/DIV start.
- zin while busy is ignored: z is not written and no restart occurs.
- Other register loads proceed while busy; captured operands are unaffected.
- Opcodes 15 and up give result=0 in the single-cycle path.
- hiin and loin load from the bus only. Software moves ZHI/ZLO to HI/LO through the bus.

Decomposition:
- Package param_datapath_pkg: alu_op codes; src_sel offsets (SRC_HI..SRC_IMM); mdr_sel codes.
- Sub-module seq_muldiv (WIDTH), owning the handshake:
  - ports: clk, reset, start, is_div, a, b, busy, done, result[2W-1:0], dbz;
  - shift-add multiplier and restoring divider, one bit per cycle, with sign correction.
- Register file, bus mux and single-cycle ALU sit in the top module.

Test Plan:
- Reset → z, pc, mdr, hi, lo, busy, done and dbz all 0; src_en=0 → bus=0.
- imm=5, mdr_sel=2, mdrin; then src=MDR, reg_we, reg_widx=3; then src=R3 → bus=0x00000005. The same with R0 and ba_mode=1 → bus=0.
- Y=7, bus=5:
  - ADD, zin → z=0x00000000_0000000C;
  - SUB → z low=0x00000002;
  - ROL with B=0x80000001, Y ignored, amount 1 → z low=0x00000003.
- Y=0xFFFFFFFD, bus=7, MUL, zin:
  - busy high cycles 1..32, done in cycle 33, z=0xFFFFFFFF_FFFFFFEB;
  - a zin issued at cycle 10 is ignored.
- DIV cases:
  - Y=0xFFFFFFEF (-17), bus=5 → z=0xFFFFFFFE_FFFFFFFD, dbz=0.
  - Then Y=9, bus=0 → z=0x00000009_FFFFFFFF, dbz=1.
- Start MUL, assert reset at cycle 5 → busy=0, z=0, and no done for 40 cycles.

Source files
------------

// File: rtl/param_datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_datapath_pkg
//  Description : Shared encodings for the parametrised single-bus datapath.
//                Holds the ALU operation codes, the bus-source offsets that
//                sit above the general-register range, and the MDR input
//                select codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package param_datapath_pkg;

    // ALU operation codes
    localparam logic [3:0] c_op_add   = 4'd0;
    localparam logic [3:0] c_op_sub   = 4'd1;
    localparam logic [3:0] c_op_and   = 4'd2;
    localparam logic [3:0] c_op_or    = 4'd3;
    localparam logic [3:0] c_op_shr   = 4'd4;
    localparam logic [3:0] c_op_shra  = 4'd5;
    localparam logic [3:0] c_op_shl   = 4'd6;
    localparam logic [3:0] c_op_ror   = 4'd7;
    localparam logic [3:0] c_op_rol   = 4'd8;
    localparam logic [3:0] c_op_neg   = 4'd9;
    localparam logic [3:0] c_op_not   = 4'd10;
    localparam logic [3:0] c_op_pass  = 4'd11;
    localparam logic [3:0] c_op_incpc = 4'd12;
    localparam logic [3:0] c_op_mul   = 4'd13;
    localparam logic [3:0] c_op_div   = 4'd14;

    // Bus-source offsets, added to NREGS to form the src_sel code
    localparam int c_src_hi  = 0;
    localparam int c_src_lo  = 1;
    localparam int c_src_zhi = 2;
    localparam int c_src_zlo = 3;
    localparam int c_src_pc  = 4;
    localparam int c_src_mdr = 5;
    localparam int c_src_imm = 6;

    // MDR input select
    localparam logic [1:0] c_mdr_bus  = 2'd0;
    localparam logic [1:0] c_mdr_mem  = 2'd1;
    localparam logic [1:0] c_mdr_imm  = 2'd2;
    localparam logic [1:0] c_mdr_zero = 2'd3;

endpackage : param_datapath_pkg
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : seq_muldiv
//  Description : Sequential signed multiplier / divider, one bit per cycle.
//                Operands are converted to magnitudes at start, processed by
//                a shift-add multiplier or a restoring divider for WIDTH
//                cycles, then sign-corrected on the final edge.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                start, is_div   - begin an operation (ignored while busy)
//                a, b            - signed operands, captured at start
//                busy            - high for exactly WIDTH cycles
//                done            - one-cycle pulse, result valid with it
//                result          - product, or {remainder, quotient}
//                dbz             - sticky divide-by-zero, cleared by start
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               dbz
);

    localparam int CNTW = $clog2(WIDTH);

    localparam logic [0:0] c_s_idle = 1'b0;
    localparam logic [0:0] c_s_run  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [CNTW-1:0]    r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_bzero;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_result;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;
    logic [2*WIDTH-1:0] w_mag;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [2*WIDTH-1:0] w_final;
    logic               w_last;
    logic               w_start_ok;

    assign w_abs_a    = a[WIDTH-1] ? -a : a;
    assign w_abs_b    = b[WIDTH-1] ? -b : b;
    assign w_start_ok = (r_state == c_s_idle) && start;
    assign w_last     = (r_state == c_s_run) && (r_cnt == CNTW'(WIDTH - 1));

    // One iteration of either algorithm. For MUL, {r_acc, r_lo} is the
    // partial product with the multiplier in r_lo; for DIV, r_acc is the
    // partial remainder and r_lo shifts the dividend out / quotient in.
    always_comb begin
        w_sum     = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_shift   = {r_acc, r_lo[WIDTH-1]};
        w_trial   = w_shift - {1'b0, r_opnd};
        w_acc_nxt = r_acc;
        w_lo_nxt  = r_lo;
        if (!r_is_div) begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_lo_nxt  = {w_sum[0], r_lo[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            // No borrow: the shifted remainder covers the divisor
            w_acc_nxt = w_trial[WIDTH-1:0];
            w_lo_nxt  = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_nxt = w_shift[WIDTH-1:0];
            w_lo_nxt  = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied to the magnitudes of the final iteration
    always_comb begin
        w_mag = {w_acc_nxt, w_lo_nxt};
        w_q   = r_neg_q ? -w_lo_nxt : w_lo_nxt;
        w_r   = r_neg_r ? -w_acc_nxt : w_acc_nxt;
        if (!r_is_div) begin
            w_final = r_neg_q ? -w_mag : w_mag;
        end else if (r_bzero) begin
            w_final = {r_a, {WIDTH{1'b1}}};
        end else begin
            w_final = {w_r, w_q};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_s_idle: if (start)  w_state_nxt = c_s_run;
            c_s_run:  if (w_last) w_state_nxt = c_s_idle;
            default:              w_state_nxt = c_s_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_a      <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_ok) begin
                r_cnt    <= '0;
                r_is_div <= is_div;
                r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                r_neg_r  <= a[WIDTH-1];
                r_bzero  <= (b == '0);
                r_a      <= a;
                r_opnd   <= is_div ? w_abs_b : w_abs_a;
                r_acc    <= '0;
                r_lo     <= is_div ? w_abs_a : w_abs_b;
                r_dbz    <= 1'b0;
            end else if (r_state == c_s_run) begin
                r_acc <= w_acc_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + CNTW'(1);
                if (w_last) begin
                    r_result <= w_final;
                    r_done   <= 1'b1;
                    if (r_is_div && r_bzero) begin
                        r_dbz <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy   = (r_state == c_s_run);
    assign done   = r_done;
    assign result = r_result;
    assign dbz    = r_dbz;

endmodule : seq_muldiv
`default_nettype wire

// File: rtl/param_bus_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : param_bus_datapath
//  Description : Parametrised single-bus CPU datapath: general register file,
//                special registers (PC, IR, MAR, MDR, Y, Z, HI, LO), encoded
//                bus-source mux, single-cycle ALU and a sequential signed
//                MUL/DIV unit with a busy/done handshake.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                src_en, src_sel, ba_mode - bus source control
//                reg_we, reg_widx        - general register write
//                pcin..mdrin, mdr_sel    - special register loads
//                imm, mem_rdata          - immediate and memory read data
//                alu_op, zin             - ALU operation / Z capture / start
//                bus, pc..lo, z          - observed bus and registers
//                busy, done, dbz         - MUL/DIV status
//  Revision    : 1.0 - initial release
// ============================================================================
module param_bus_datapath
    import param_datapath_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int SELW  = $clog2(NREGS + 8)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     src_en,
    input  logic [SELW-1:0]          src_sel,
    input  logic                     ba_mode,
    input  logic                     reg_we,
    input  logic [$clog2(NREGS)-1:0] reg_widx,
    input  logic                     pcin,
    input  logic                     irin,
    input  logic                     marin,
    input  logic                     yin,
    input  logic                     hiin,
    input  logic                     loin,
    input  logic                     mdrin,
    input  logic [1:0]               mdr_sel,
    input  logic [WIDTH-1:0]         imm,
    input  logic [WIDTH-1:0]         mem_rdata,
    input  logic [3:0]               alu_op,
    input  logic                     zin,
    output logic [WIDTH-1:0]         bus,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         ir,
    output logic [WIDTH-1:0]         mar,
    output logic [WIDTH-1:0]         mdr,
    output logic [WIDTH-1:0]         y,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo,
    output logic [2*WIDTH-1:0]       z,
    output logic                     busy,
    output logic                     done,
    output logic                     dbz
);

    localparam int RIDXW = $clog2(NREGS);
    localparam int SHW   = $clog2(WIDTH);

    logic [WIDTH-1:0]   r_regs [NREGS];
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_ir;
    logic [WIDTH-1:0]   r_mar;
    logic [WIDTH-1:0]   r_mdr;
    logic [WIDTH-1:0]   r_y;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_z;

    logic [WIDTH-1:0]   w_bus;
    logic [SELW-1:0]    w_ofs;
    logic [WIDTH-1:0]   w_mdr_in;
    logic [WIDTH-1:0]   w_alu;
    logic [SHW-1:0]     w_sh;
    logic [31:0]        w_sh32;
    logic [SHW-1:0]     w_rot;
    logic [2*WIDTH-1:0] w_z;
    logic               w_is_md;
    logic               w_md_start;
    logic               w_z_single;
    logic               w_md_busy;
    logic               w_md_done;
    logic               w_md_dbz;
    logic [2*WIDTH-1:0] w_md_result;

    // Z as seen by the outside world: during the done pulse the MUL/DIV
    // result is presented directly and folded into r_z on the next edge.
    assign w_z = w_md_done ? w_md_result : r_z;

    always_comb begin
        w_bus = '0;
        w_ofs = src_sel - SELW'(NREGS);
        if (src_en) begin
            if (src_sel < SELW'(NREGS)) begin
                if (!(ba_mode && (src_sel == '0))) begin
                    w_bus = r_regs[src_sel[RIDXW-1:0]];
                end
            end else begin
                case (w_ofs)
                    SELW'(c_src_hi):  w_bus = r_hi;
                    SELW'(c_src_lo):  w_bus = r_lo;
                    SELW'(c_src_zhi): w_bus = w_z[2*WIDTH-1:WIDTH];
                    SELW'(c_src_zlo): w_bus = w_z[WIDTH-1:0];
                    SELW'(c_src_pc):  w_bus = r_pc;
                    SELW'(c_src_mdr): w_bus = r_mdr;
                    SELW'(c_src_imm): w_bus = imm;
                    default:          w_bus = '0;
                endcase
            end
        end
    end

    always_comb begin
        case (mdr_sel)
            c_mdr_bus: w_mdr_in = w_bus;
            c_mdr_mem: w_mdr_in = mem_rdata;
            c_mdr_imm: w_mdr_in = imm;
            default:   w_mdr_in = '0;
        endcase
    end

    // Shifts and rotates act on B, with the amount taken from B's low bits.
    // Rotation is reduced modulo WIDTH so non-power-of-two widths still wrap.
    always_comb begin
        w_sh   = w_bus[SHW-1:0];
        w_sh32 = 32'(w_sh);
        w_rot  = SHW'(w_sh32 % WIDTH);
        case (alu_op)
            c_op_add:   w_alu = r_y + w_bus;
            c_op_sub:   w_alu = r_y - w_bus;
            c_op_and:   w_alu = r_y & w_bus;
            c_op_or:    w_alu = r_y | w_bus;
            c_op_shr:   w_alu = w_bus >> w_sh;
            c_op_shra:  w_alu = WIDTH'($signed(w_bus) >>> w_sh);
            c_op_shl:   w_alu = w_bus << w_sh;
            c_op_ror:   w_alu = (w_bus >> w_rot) | (w_bus << (WIDTH - int'(w_rot)));
            c_op_rol:   w_alu = (w_bus << w_rot) | (w_bus >> (WIDTH - int'(w_rot)));
            c_op_neg:   w_alu = -w_bus;
            c_op_not:   w_alu = ~w_bus;
            c_op_pass:  w_alu = w_bus;
            c_op_incpc: w_alu = w_bus + WIDTH'(1);
            default:    w_alu = '0;
        endcase
    end

    assign w_is_md    = (alu_op == c_op_mul) || (alu_op == c_op_div);
    assign w_md_start = zin && !w_md_busy && w_is_md;
    assign w_z_single = zin && !w_md_busy && !w_is_md;

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (w_md_start),
        .is_div (alu_op == c_op_div),
        .a      (r_y),
        .b      (w_bus),
        .busy   (w_md_busy),
        .done   (w_md_done),
        .result (w_md_result),
        .dbz    (w_md_dbz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_z   <= '0;
        end else begin
            if (reg_we) r_regs[reg_widx] <= w_bus;
            if (pcin)   r_pc  <= w_bus;
            if (irin)   r_ir  <= w_bus;
            if (marin)  r_mar <= w_bus;
            if (yin)    r_y   <= w_bus;
            if (hiin)   r_hi  <= w_bus;
            if (loin)   r_lo  <= w_bus;
            if (mdrin)  r_mdr <= w_mdr_in;
            // A single-cycle capture in the done cycle wins over folding in
            // the MUL/DIV result, which has already been observed on z.
            if (w_z_single) begin
                r_z <= {{WIDTH{1'b0}}, w_alu};
            end else if (w_md_done) begin
                r_z <= w_md_result;
            end
        end
    end

    assign bus  = w_bus;
    assign pc   = r_pc;
    assign ir   = r_ir;
    assign mar  = r_mar;
    assign mdr  = r_mdr;
    assign y    = r_y;
    assign hi   = r_hi;
    assign lo   = r_lo;
    assign z    = w_z;
    assign busy = w_md_busy;
    assign done = w_md_done;
    assign dbz  = w_md_dbz;

endmodule : param_bus_datapath
`default_nettype wire

// File: tb/tb_param_bus_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_bus_datapath
//  Description : Self-checking bench for param_bus_datapath (WIDTH=32,
//                NREGS=16). Directed steps plus randomized ALU and MUL/DIV
//                operations compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_bus_datapath;

    localparam int W = 32;
    localparam int N = 16;

    localparam logic [4:0] S_HI  = 5'd16;
    localparam logic [4:0] S_LO  = 5'd17;
    localparam logic [4:0] S_ZHI = 5'd18;
    localparam logic [4:0] S_ZLO = 5'd19;
    localparam logic [4:0] S_MDR = 5'd21;
    localparam logic [4:0] S_IMM = 5'd22;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_DIV = 4'd14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, src_en, ba_mode, reg_we;
    logic [4:0]   src_sel;
    logic [3:0]   reg_widx;
    logic         pcin, irin, marin, yin, hiin, loin, mdrin, zin;
    logic [1:0]   mdr_sel;
    logic [W-1:0] imm, mem_rdata;
    logic [3:0]   alu_op;
    logic [W-1:0] bus, pc, ir, mar, mdr, y, hi, lo;
    logic [2*W-1:0] z;
    logic         busy, done, dbz;

    param_bus_datapath #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .reset(reset), .src_en(src_en), .src_sel(src_sel),
        .ba_mode(ba_mode), .reg_we(reg_we), .reg_widx(reg_widx),
        .pcin(pcin), .irin(irin), .marin(marin), .yin(yin), .hiin(hiin),
        .loin(loin), .mdrin(mdrin), .mdr_sel(mdr_sel), .imm(imm),
        .mem_rdata(mem_rdata), .alu_op(alu_op), .zin(zin), .bus(bus),
        .pc(pc), .ir(ir), .mar(mar), .mdr(mdr), .y(y), .hi(hi), .lo(lo),
        .z(z), .busy(busy), .done(done), .dbz(dbz)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] m_z = '0;   // model of the visible Z register

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        src_en = 0; src_sel = '0; ba_mode = 0; reg_we = 0; reg_widx = '0;
        pcin = 0; irin = 0; marin = 0; yin = 0; hiin = 0; loin = 0; mdrin = 0;
        mdr_sel = '0; imm = '0; mem_rdata = '0; alu_op = '0; zin = 0;
    endtask

    task automatic drive_imm(input logic [W-1:0] v);
        src_en = 1; src_sel = S_IMM; imm = v;
    endtask

    task automatic load_y(input logic [W-1:0] v);
        drive_imm(v); yin = 1; tick(); yin = 0;
    endtask

    // Reference ALU: rotates are done one position at a time
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        logic [W-1:0] t;
        s = int'(b[4:0]);
        t = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return b >> s;
            4'd5:  return W'($signed(b) >>> s);
            4'd6:  return b << s;
            4'd7:  begin for (int i = 0; i < s; i++) t = {t[0], t[W-1:1]}; return t; end
            4'd8:  begin for (int i = 0; i < s; i++) t = {t[W-2:0], t[W-1]}; return t; end
            4'd9:  return 32'd0 - b;
            4'd10: return ~b;
            4'd11: return b;
            4'd12: return b + 32'd1;
            default: return '0;
        endcase
    endfunction

    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MUL) return 64'(sa * sb);
        if (b == '0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_single(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [63:0] exp);
        load_y(a);
        drive_imm(b); alu_op = op; zin = 1;
        tick();
        zin = 0;
        m_z = exp;
        check(tag, z, exp);
    endtask

    // Runs a MUL/DIV; when zin_at is 1..W a spurious ADD capture is attempted
    // in that busy cycle and must leave z untouched.
    task automatic do_md(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] exp, input int zin_at);
        int bad;
        load_y(a);
        drive_imm(b); alu_op = op; zin = 1;
        tick();
        zin = 0;
        bad = 0;
        for (int c = 1; c <= W; c++) begin
            if (busy !== 1'b1 || done !== 1'b0 || z !== m_z) bad++;
            if (c == zin_at) begin
                alu_op = OP_ADD; drive_imm($urandom); zin = 1;
            end else begin
                drive_imm($urandom);
            end
            tick();
            zin = 0; alu_op = op;
        end
        check({tag, "_busy_window"}, 64'(bad), 64'd0);
        check({tag, "_done"}, {62'd0, busy, done}, 64'd1);
        check({tag, "_z"}, z, exp);
        check({tag, "_dbz"}, 64'(dbz), 64'((op == OP_DIV) && (b == '0)));
        m_z = exp;
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_z_hold"}, z, exp);
    endtask

    initial begin
        logic [3:0]   op;
        logic [W-1:0] ra, rb;
        int           cnt;

        clear_ctrl();
        reset = 1;
        tick(); tick();
        reset = 0;

        check("rst_z",    z,   64'd0);
        check("rst_pc",   64'(pc),  64'd0);
        check("rst_mdr",  64'(mdr), 64'd0);
        check("rst_hi",   64'(hi),  64'd0);
        check("rst_lo",   64'(lo),  64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz",  64'(dbz),  64'd0);
        imm = 32'hDEAD_BEEF; src_sel = S_IMM; #1;
        check("bus_src_en0", 64'(bus), 64'd0);

        // MDR from imm, then into R3, then read R3 back on the bus
        imm = 32'd5; mdr_sel = 2'd2; mdrin = 1;
        tick();
        mdrin = 0;
        check("mdr_imm", 64'(mdr), 64'd5);
        src_en = 1; src_sel = S_MDR; reg_we = 1; reg_widx = 4'd3;
        tick();
        reg_widx = 4'd0;
        tick();
        reg_we = 0;
        src_sel = 5'd3; #1;
        check("bus_r3", 64'(bus), 64'h0000_0005);
        src_sel = 5'd0; ba_mode = 1; #1;
        check("bus_r0_ba", 64'(bus), 64'd0);
        ba_mode = 0; #1;
        check("bus_r0_plain", 64'(bus), 64'd5);
        src_sel = 5'd23; #1;
        check("bus_bad_code", 64'(bus), 64'd0);

        // MDR from memory and zero
        mem_rdata = 32'h1357_9BDF; mdr_sel = 2'd1; mdrin = 1;
        tick();
        check("mdr_mem", 64'(mdr), 64'h1357_9BDF);
        mdr_sel = 2'd3;
        tick();
        mdrin = 0;
        check("mdr_zero", 64'(mdr), 64'd0);

        // Simultaneous loads from one bus value
        drive_imm(32'hA5A5_0F0F); pcin = 1; irin = 1; marin = 1; hiin = 1; loin = 1;
        tick();
        pcin = 0; irin = 0; marin = 0; hiin = 0; loin = 0;
        check("multi_pc",  64'(pc),  64'hA5A5_0F0F);
        check("multi_ir",  64'(ir),  64'hA5A5_0F0F);
        check("multi_mar", 64'(mar), 64'hA5A5_0F0F);
        check("multi_hilo", {hi, lo}, 64'hA5A5_0F0F_A5A5_0F0F);

        // Directed single-cycle ops
        do_single("add", OP_ADD, 32'd7, 32'd5, 64'h0000_0000_0000_000C);
        do_single("sub", OP_SUB, 32'd7, 32'd5, 64'h0000_0000_0000_0002);
        do_single("rol", OP_ROL, 32'd7, 32'h8000_0001, 64'h0000_0000_0000_0003);
        do_single("op15", 4'd15, 32'd7, 32'd5, 64'd0);
        check("y_value", 64'(y), 64'd7);

        // Multi-cycle ops
        do_md("mul", OP_MUL, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 10);
        src_sel = S_ZHI; #1;
        check("bus_zhi", 64'(bus), 64'hFFFF_FFFF);
        src_sel = S_ZLO; loin = 1;
        tick();
        loin = 0;
        check("lo_from_zlo", 64'(lo), 64'hFFFF_FFEB);
        src_sel = S_LO; #1;
        check("bus_lo", 64'(bus), 64'hFFFF_FFEB);
        src_sel = S_HI; #1;
        check("bus_hi", 64'(bus), 64'hA5A5_0F0F);
        do_md("div", OP_DIV, 32'hFFFF_FFEF, 32'd5, 64'hFFFF_FFFE_FFFF_FFFD, 0);
        do_md("div0", OP_DIV, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF, 0);

        // Randomized single-cycle ops
        for (int k = 0; k < 30; k++) begin
            op = 4'($urandom_range(0, 12));
            if ($urandom_range(0, 9) == 0) op = 4'd15;
            ra = $urandom;
            rb = $urandom;
            do_single("rnd_alu", op, ra, rb, {32'd0, ref_alu(op, ra, rb)});
        end

        // Randomized MUL/DIV, with occasional zero divisor and spurious zin
        for (int k = 0; k < 6; k++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_MUL : OP_DIV;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            do_md("rnd_md", op, ra, rb, ref_md(op, ra, rb), int'($urandom_range(0, W)));
        end

        // Reset in the middle of a MUL: aborted, no done afterwards
        load_y(32'd3);
        drive_imm(32'd4); alu_op = OP_MUL; zin = 1;
        tick();
        zin = 0;
        for (int c = 1; c < 5; c++) tick();
        reset = 1;
        tick();
        reset = 0;
        m_z = '0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_z", z, 64'd0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) cnt++;
            tick();
        end
        check("abort_no_done", 64'(cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_param_bus_datapath
`default_nettype wire
